// File: rtl/shift_rows_pipe.sv
// Flow-controlled AES/Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8,
// with the transformed state queued in a DEPTH-entry output FIFO.
module shift_rows_pipe #(
  parameter int WORD_SIZE = 8,
  parameter int NB        = 4,
  parameter int DEPTH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_inv,
  input  logic [WORD_SIZE*4*NB-1:0]      in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_inv,
  output logic [WORD_SIZE*4*NB-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int DW = WORD_SIZE * 4 * NB;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("shift_rows_pipe: DEPTH must be at least 1");
    end
  endgenerate

  // Rijndael row offsets: 0,1,2,3 for Nb = 4/6; 0,1,3,4 for Nb = 8.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [DW-1:0] shifted;

  // Byte k = 4c + r sits at the top of the bus for k = 0.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (in_inv)
          shifted[DW-1-WORD_SIZE*(4*c+r) -: WORD_SIZE] =
            in_data[DW-1-WORD_SIZE*(4*((c + NB - row_shift(r)) % NB) + r) -: WORD_SIZE];
        else
          shifted[DW-1-WORD_SIZE*(4*c+r) -: WORD_SIZE] =
            in_data[DW-1-WORD_SIZE*(4*((c + row_shift(r)) % NB) + r) -: WORD_SIZE];
      end
    end
  end

  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign in_ready  = (count < FULL_CNT) && !clear;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !clear;

  // NOTE: the storage array has no reset; out_valid and last_q decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_inv, shifted};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      // Remember the current head so the outputs hold once the FIFO drains.
      if (out_valid) last_q <= mem[rd_ptr];
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= bump(wr_ptr);
        if (pop)  rd_ptr <= bump(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign {out_inv, out_data} = out_valid ? mem[rd_ptr] : last_q;

endmodule
